print_arbiter: RTL and testbench

Shares the single UART print path (the word/byte print engine driving the UART transmitter) between up to `NREQ` requesters, such as command echo, register dump and memory dump. Grants are round-robin. For each grant the block presents the data and type to the print engine, then raises a clean rising edge on `req_tx`. It waits for `ack_tx` and returns a one-cycle acknowledge to the winner. A watchdog aborts a grant whose engine never acknowledges.

---
 rtl/print_arbiter_pkg.sv | 15 +
 rtl/print_arbiter_rr_picker.sv | 35 +++
 rtl/print_arbiter.sv | 100 ++++++++++
 tb/tb_print_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/print_arbiter_pkg.sv
// Shared types for the UART print-path arbiter: FSM states and print type encoding.
package print_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    DONE,
    RELEASE
  } state_e;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

endpackage

// File: rtl/print_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // Doubling the vector makes the right shift a rotation by ptr.
  assign rot = NREQ'({req, req} >> ptr);
  assign any = |req;

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/print_arbiter.sv
// Round-robin arbiter sharing the UART print engine between NREQ requesters,
// with a clean req_tx rising edge per grant and an ISSUE-state watchdog.
module print_arbiter
  import print_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    type_i,
  input  logic [32*NREQ-1:0] data_i,
  output logic [NREQ-1:0]    ack_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [IW-1:0]      grant_o,
  output logic               req_tx,
  output logic               type_tx,
  output logic [31:0]        dout_tx,
  input  logic               ack_tx
);

  localparam int          WW      = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_e               state, nxt;
  logic [IW-1:0]        ptr;
  logic [WW-1:0]        wd;
  logic                 abort;
  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic [NREQ-1:0][31:0] data_v;

  assign data_v = data_i;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_i),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    nxt    = state;
    req_tx = 1'b0;
    ack_o  = '0;
    err_o  = 1'b0;
    busy_o = (state != IDLE);
    case (state)
      IDLE:    if (pick_any) nxt = SETUP;
      SETUP:   nxt = ISSUE;
      ISSUE: begin
        req_tx = 1'b1;
        if (ack_tx || wd == WD_LAST) nxt = DONE;
      end
      DONE: begin
        ack_o = NREQ'(1) << grant_o;
        err_o = abort;
        nxt   = RELEASE;
      end
      RELEASE: if (!ack_tx) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ptr     <= '0;
      wd      <= '0;
      abort   <= 1'b0;
      grant_o <= '0;
      dout_tx <= '0;
      type_tx <= TYPE_BYTE;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (pick_any) begin
          grant_o <= pick_idx;
          dout_tx <= data_v[pick_idx];
          type_tx <= type_i[pick_idx];
        end
        ISSUE: begin
          // Saturating: never wraps even if TIMEOUT is a power of two minus one.
          if (wd != '1) wd <= wd + 1'b1;
          if (!ack_tx && wd == WD_LAST) abort <= 1'b1;
        end
        DONE: begin
          ptr   <= (grant_o == IW'(NREQ - 1)) ? '0 : grant_o + 1'b1;
          wd    <= '0;
          abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_print_arbiter.sv
// Self-checking bench for print_arbiter: directed scenarios plus randomized grants
// against a rotation-pointer reference model.
module tb_print_arbiter;
  import print_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [N-1:0]       req_i = '0;
  logic [N-1:0]       type_i = '0;
  logic [N-1:0][31:0] data_i = '0;
  logic               ack_tx = 1'b0;
  logic [N-1:0]       ack_o;
  logic               err_o, busy_o, req_tx, type_tx;
  logic [IW-1:0]      grant_o;
  logic [31:0]        dout_tx;

  int checks = 0;
  int errors = 0;
  int mptr = 0;
  int rises = 0;
  int last_grant = 0;

  print_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (req_i),
    .type_i  (type_i),
    .data_i  (data_i),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .busy_o  (busy_o),
    .grant_o (grant_o),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .dout_tx (dout_tx),
    .ack_tx  (ack_tx)
  );

  always #5 clk = ~clk;

  // Engine-side edge detector.
  always @(posedge req_tx) rises++;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic rand_data;
    for (int k = 0; k < N; k++) data_i[k] = $urandom;
    type_i = N'($urandom);
  endtask

  // Entered on a cycle where the DUT is IDLE and req_i is already set.
  // lat < 0: engine never acks (watchdog path). h: extra RELEASE cycles with ack_tx held.
  task automatic run_grant(input int lat, input int h, input logic [N-1:0] nreq);
    int idx;
    logic [31:0] ed;
    logic et;
    idx = pick(req_i, mptr);
    chk("pick_valid", 64'(idx >= 0), 64'd1);
    if (idx < 0) return;
    ed = data_i[idx];
    et = type_i[idx];
    if (lat == 0) ack_tx = 1'b1;
    tick;
    chk("setup_req_tx", req_tx, 0);
    chk("setup_busy", busy_o, 1);
    chk("setup_latch", {grant_o, type_tx, dout_tx}, {IW'(idx), et, ed});
    tick;
    chk("issue_req_tx", req_tx, 1);
    req_i = nreq;
    rand_data();
    if (lat >= 0) begin
      for (int k = 0; k < lat; k++) begin
        tick;
        chk("issue_hold", {req_tx, ack_o, dout_tx}, {1'b1, 4'b0, ed});
      end
      ack_tx = 1'b1;
      tick;
      chk("done_ack", ack_o, 64'(1) << idx);
      chk("done_err", err_o, 0);
    end else begin
      for (int k = 0; k < TO - 1; k++) begin
        tick;
        chk("wd_wait", {req_tx, ack_o}, {1'b1, 4'b0});
      end
      tick;
      chk("to_ack", ack_o, 64'(1) << idx);
      chk("to_err", err_o, 1);
    end
    chk("done_req_tx", req_tx, 0);
    last_grant = idx;
    mptr = (idx + 1) % N;
    rand_data();
    if (lat >= 0) begin
      for (int k = 0; k < h; k++) begin
        tick;
        chk("release", {busy_o, ack_o, err_o, req_tx}, {1'b1, 4'b0, 1'b0, 1'b0});
      end
      ack_tx = 1'b0;
    end else begin
      tick;
      chk("to_release_busy", busy_o, 1);
    end
    tick;
    chk("idle_busy", {busy_o, ack_o}, 0);
    chk("idle_hold", {grant_o, type_tx, dout_tx}, {IW'(idx), et, ed});
  endtask

  initial begin
    int r0, lat, h;
    logic [N-1:0] nreq;
    tick;
    tick;
    chk("reset_outs", {req_tx, type_tx, dout_tx, ack_o, err_o, busy_o, grant_o}, 0);
    rstn = 1'b1;
    tick;
    chk("reset_idle", busy_o, 0);

    // Round-robin with all requests held.
    req_i = '1;
    rand_data();
    for (int i = 0; i < 5; i++) begin
      run_grant(3, 1, 4'hF);
      chk("rr_order", last_grant, i % N);
    end

    // Single word request.
    req_i = 4'b0001;
    data_i[0] = 32'h1234ABCD;
    type_i[0] = TYPE_WORD;
    run_grant(5, 1, 4'b0000);
    chk("single_grant", last_grant, 0);
    tick;
    chk("quiet_idle", {busy_o, req_tx}, 0);

    // Watchdog abort.
    req_i = 4'b0010;
    run_grant(-1, 0, 4'b0000);
    chk("to_grant", last_grant, 1);

    // Back-to-back 2 then 3: two distinct rising edges.
    r0 = rises;
    req_i = 4'b1100;
    run_grant(2, 1, 4'b1000);
    chk("b2b_first", last_grant, 2);
    run_grant(1, 2, 4'b0000);
    chk("b2b_second", last_grant, 3);
    chk("b2b_rises", rises - r0, 2);

    // Late request from 0 during requester 2's ISSUE.
    req_i = 4'b0100;
    run_grant(4, 1, 4'b0101);
    chk("late_cur", last_grant, 2);
    run_grant(2, 1, 4'b0100);
    chk("late_next", last_grant, 0);
    run_grant(1, 1, 4'b0000);
    chk("late_after", last_grant, 2);

    // Reset mid-ISSUE with ptr at 2: re-arbitration must restart from 0.
    req_i = 4'b0010;
    run_grant(1, 1, 4'b0000);
    req_i = 4'b1000;
    tick;
    tick;
    chk("rst_pre_issue", req_tx, 1);
    rstn = 1'b0;
    #1;
    chk("rst_async_outs", {req_tx, type_tx, dout_tx, ack_o, err_o, busy_o, grant_o}, 0);
    tick;
    chk("rst_no_ack", ack_o, 0);
    rstn = 1'b1;
    req_i = 4'b0110;
    mptr = 0;
    run_grant(2, 1, 4'b0000);
    chk("rst_first_grant", last_grant, 1);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      while (req_i == '0) req_i = N'($urandom);
      if ($urandom_range(0, 7) == 0) lat = -1;
      else lat = int'($urandom_range(0, 5));
      h = int'($urandom_range(1, 3));
      nreq = N'($urandom);
      run_grant(lat, h, nreq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
